// File: rtl/trace_pkg.sv
// Shared constants, record layout and serializer state encodings for trace capture.
package trace_pkg;

    localparam int          DEFAULT_WIDTH  = 8;
    localparam int          RECORD_BYTES   = 6;
    localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;

    // Captured architectural state; pc occupies the most significant byte.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] pc;
        logic [DEFAULT_WIDTH-1:0] ir;
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
        logic [DEFAULT_WIDTH-1:0] x;
        logic [DEFAULT_WIDTH-1:0] q;
    } record_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO: DEPTH entries of W bits, head visible combinationally while not empty.
module trace_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              dout,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Record storage; contents are only meaningful behind the occupancy count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/trace_capture.sv
// Snapshots CPU state on each step strobe and streams it out as framed bytes.
module trace_capture
    import trace_pkg::*;
#(
    parameter int               WIDTH  = DEFAULT_WIDTH,
    parameter int               DEPTH  = 4,
    parameter logic [WIDTH-1:0] HEADER = WIDTH'(DEFAULT_HEADER)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step,
    input  logic [WIDTH-1:0]        pc,
    input  logic [WIDTH-1:0]        ir,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic [WIDTH-1:0]        x,
    input  logic [WIDTH-1:0]        q,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic [7:0]              dropped
);

    localparam int REC_W = WIDTH * RECORD_BYTES;

    state_t             state, state_n;
    logic [2:0]         idx, idx_n;
    logic [REC_W-1:0]   shadow, shadow_n;
    logic [REC_W-1:0]   fifo_dout;
    logic               out_valid_n;
    logic [WIDTH-1:0]   out_data_n;
    logic               pop;
    logic               full;
    logic               empty;
    logic               xfer;

    // Field i of a record, counting from pc (0) down to q (5).
    function automatic logic [WIDTH-1:0] field_sel(input logic [REC_W-1:0] rec,
                                                   input logic [2:0] i);
        logic [REC_W-1:0] sh;
        sh = rec >> (WIDTH * (RECORD_BYTES - 1 - int'(i)));
        return sh[WIDTH-1:0];
    endfunction

    trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (step),
        .pop   (pop),
        .din   ({pc, ir, a, b, x, q}),
        .dout  (fifo_dout),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign xfer = out_valid && out_ready;

    // Serializer next-state: pop a record into the shadow at frame start, then walk its fields.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        shadow_n    = shadow;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    shadow_n    = fifo_dout;
                    state_n     = HDR;
                    out_valid_n = 1'b1;
                    out_data_n  = HEADER;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_n    = BODY;
                    idx_n      = 3'd0;
                    out_data_n = field_sel(shadow, 3'd0);
                end
            end
            BODY: begin
                if (xfer) begin
                    if (idx == 3'(RECORD_BYTES - 1)) begin
                        if (!empty) begin
                            pop        = 1'b1;
                            shadow_n   = fifo_dout;
                            state_n    = HDR;
                            out_data_n = HEADER;
                        end else begin
                            state_n     = IDLE;
                            out_valid_n = 1'b0;
                        end
                    end else begin
                        idx_n      = idx + 3'd1;
                        out_data_n = field_sel(shadow, idx + 3'd1);
                    end
                end
            end
            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
            end
        endcase
    end

    // Serializer registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            shadow    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            shadow    <= shadow_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
        end
    end

    // Overflow counter: a step into a full FIFO with no pop on that edge is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped <= 8'd0;
        end else if (step && full && !pop && (dropped != 8'hFF)) begin
            dropped <= dropped + 8'd1;
        end
    end

endmodule
